// File: rtl/result_reader.sv
// result_reader: reads a block of words from a synchronous SRAM and
// serialises each word MSB first onto a single-bit downstream stream.
// One word is held in a buffer while the previous word is being shifted
// out, so consecutive words stream without idle bit slots.
//
// Downstream handshake: P_valid says P_out holds a bit; a bit is consumed
// on a rising edge where P_valid=1 and P_s=1. P_s while P_valid=0 has no
// effect. P_valid does not drop until its bit is consumed.
//
// SRAM handshake: cs_n is low for exactly one cycle per request. The
// address is then held and the block waits, without a timeout, for ry=1.
// read_data is captured on that edge. Only one request is in flight at a
// time.
module result_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   output logic              cs_n,
   output logic              we_n,
   output logic [ADDR_W-1:0] address,
   input  logic              ry,
   input  logic [DATA_W-1:0] read_data,
   input  logic              P_s,
   output logic              P_out,
   output logic              P_valid,
   output logic              busy,
   output logic              read_done,
   output logic [2:0]        dbg_state
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t            state;

   // Parameters of the readout in progress, latched when start is accepted
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   num_q;
   // Number of words requested so far (counted as each REQ cycle ends)
   logic [ADDR_W:0]   req_cnt;

   // One-word holding buffer between SRAM and shifter
   logic [DATA_W-1:0] buf_data;
   logic              buf_full;

   // Output shifter: MSB is the current bit, sh_cnt counts bits consumed
   logic [DATA_W-1:0] sh_data;
   logic [CNT_W-1:0]  sh_cnt;
   logic              sh_valid;

   logic              consume;
   logic              sh_last;
   logic              sh_load;
   logic              capture;
   logic              words_left;
   logic [ADDR_W-1:0] next_addr;

   // Handshake and data-movement decisions for the current cycle
   always_comb begin
      consume    = P_s && sh_valid;
      sh_last    = consume && (sh_cnt == LAST_BIT);
      // Shifter takes the buffered word when it is idle or finishing now
      sh_load    = buf_full && (!sh_valid || sh_last);
      capture    = (state == WAIT) && ry;
      words_left = (req_cnt < num_q);
      // Address arithmetic wraps naturally at 2^ADDR_W
      next_addr  = base_q + req_cnt[ADDR_W-1:0];
   end

   // Control FSM with registered SRAM strobes and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         base_q    <= '0;
         num_q     <= '0;
         req_cnt   <= '0;
         cs_n      <= 1'b1;
         address   <= '0;
         busy      <= 1'b0;
         read_done <= 1'b0;
      end else begin
         read_done <= 1'b0;
         cs_n      <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     // Empty readout completes immediately without SRAM traffic
                     read_done <= 1'b1;
                  end else begin
                     base_q  <= base_addr;
                     num_q   <= num_words;
                     req_cnt <= '0;
                     address <= base_addr;
                     cs_n    <= 1'b0;
                     busy    <= 1'b1;
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
               req_cnt <= req_cnt + 1'b1;
               state   <= WAIT;
            end
            WAIT: begin
               if (ry) begin
                  if (!words_left) begin
                     state <= DRAIN;
                  end else if (!sh_valid || sh_last) begin
                     // Shifter is empty after this edge, so it will take the
                     // new word next cycle and free the buffer well before
                     // the following capture.
                     address <= next_addr;
                     cs_n    <= 1'b0;
                     state   <= REQ;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!buf_full) begin
                  address <= next_addr;
                  cs_n    <= 1'b0;
                  state   <= REQ;
               end
            end
            DRAIN: begin
               if (!buf_full && sh_last) begin
                  busy      <= 1'b0;
                  read_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Holding buffer and output shifter datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_data <= '0;
         buf_full <= 1'b0;
         sh_data  <= '0;
         sh_cnt   <= '0;
         sh_valid <= 1'b0;
      end else begin
         // A capture only happens while the buffer is empty, so it never
         // coincides with the shifter draining the buffer.
         if (capture) begin
            buf_data <= read_data;
            buf_full <= 1'b1;
         end else if (sh_load) begin
            buf_full <= 1'b0;
         end

         if (sh_load) begin
            sh_data  <= buf_data;
            sh_cnt   <= '0;
            sh_valid <= 1'b1;
         end else if (consume) begin
            sh_data <= {sh_data[DATA_W-2:0], 1'b0};
            if (sh_cnt == LAST_BIT) begin
               sh_cnt   <= '0;
               sh_valid <= 1'b0;
            end else begin
               sh_cnt <= sh_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign we_n      = 1'b1;
   assign P_valid   = sh_valid;
   assign P_out     = sh_valid & sh_data[DATA_W-1];
   assign dbg_state = state;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: behavioural SRAM with programmable ready delay,
// downstream strobe generator, and a word scoreboard fed from the memory
// image at the time each readout is started.
module tb_result_reader;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_words = '0;
   logic          cs_n;
   logic          we_n;
   logic [AW-1:0] address;
   logic          ry = 1'b0;
   logic [DW-1:0] read_data = '0;
   logic          P_s = 1'b0;
   logic          P_out;
   logic          P_valid;
   logic          busy;
   logic          read_done;
   logic [2:0]    dbg_state;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mem [256];
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] addr_q[$];

   int            cyc = 0;
   int            sram_delay = 0;
   bit            pending = 0;
   int            pend_cnt = 0;
   logic [AW-1:0] cur_addr = '0;
   int            cs_pulses = 0;
   int            ps_mode = 0;
   bit            hold_seen = 0;
   int            first_valid_cyc = -1;
   int            last_valid_cyc = -1;
   int            last_cons_cyc = -1;
   int            valid_cnt = 0;
   int            bit_cnt = 0;
   logic [DW-1:0] acc = '0;
   int            start_cyc = 0;

   result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_words(num_words), .cs_n(cs_n), .we_n(we_n), .address(address),
      .ry(ry), .read_data(read_data), .P_s(P_s), .P_out(P_out),
      .P_valid(P_valid), .busy(busy), .read_done(read_done),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / cycle counter ----------------
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- SRAM model ----------------
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (ry) ry = 1'b0;
         if (pending) begin
            checks++;
            if (address !== cur_addr || cs_n !== 1'b1) begin
               errors++;
               $display("FAIL wait_stable: address=%h cs_n=%b required address=%h cs_n=1",
                        address, cs_n, cur_addr);
            end
            if (pend_cnt == 0) begin
               ry        = 1'b1;
               read_data = mem[cur_addr];
               pending   = 0;
            end else begin
               pend_cnt--;
            end
         end else if (cs_n === 1'b0) begin
            cs_pulses++;
            cur_addr = address;
            addr_q.push_back(address);
            pending  = 1;
            pend_cnt = sram_delay;
         end
      end
   end

   // ---------------- downstream strobe driver ----------------
   initial forever begin
      @(posedge clk);
      #1;
      case (ps_mode)
         0: P_s = 1'b1;
         1: P_s = ~P_s;
         default: P_s = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- output monitor / scoreboard ----------------
   initial forever begin
      logic [DW-1:0] exp_w;
      @(negedge clk);
      if (rst) begin
         if (dbg_state == ST_HOLD) hold_seen = 1;
         if (!P_valid) begin
            checks++;
            if (P_out !== 1'b0) begin
               errors++;
               $display("FAIL idle_pout: P_out=%b required 0", P_out);
            end
         end else begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            valid_cnt++;
            if (P_s) begin
               acc = {acc[DW-2:0], P_out};
               bit_cnt++;
               last_cons_cyc = cyc;
               if (bit_cnt == DW) begin
                  bit_cnt = 0;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL word_unexpected: got %h required none", acc);
                  end else begin
                     exp_w = exp_q.pop_front();
                     if (acc !== exp_w) begin
                        errors++;
                        $display("FAIL word_data: got %h required %h", acc, exp_w);
                     end
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_words(input logic [AW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] a;
         a = base + AW'(i);
         exp_q.push_back(mem[a]);
      end
   endtask

   task automatic clear_track();
      cs_pulses       = 0;
      hold_seen       = 0;
      first_valid_cyc = -1;
      last_valid_cyc  = -1;
      last_cons_cyc   = -1;
      valid_cnt       = 0;
      addr_q.delete();
   endtask

   task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] n);
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = base;
      num_words = n;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok, output int done_cyc);
      ok       = 0;
      done_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (read_done) begin
            ok       = 1;
            done_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic flush_after_reset();
      exp_q.delete();
      pending = 0;
      ry      = 1'b0;
      bit_cnt = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks += 8;
      if (cs_n !== 1'b1)      begin errors++; $display("FAIL rst_cs_n: got %b required 1", cs_n); end
      if (we_n !== 1'b1)      begin errors++; $display("FAIL rst_we_n: got %b required 1", we_n); end
      if (address !== '0)     begin errors++; $display("FAIL rst_address: got %h required 00", address); end
      if (P_out !== 1'b0)     begin errors++; $display("FAIL rst_p_out: got %b required 0", P_out); end
      if (P_valid !== 1'b0)   begin errors++; $display("FAIL rst_p_valid: got %b required 0", P_valid); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
      if (read_done !== 1'b0) begin errors++; $display("FAIL rst_read_done: got %b required 0", read_done); end
      if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_single_word();
      bit ok;
      int dc;
      clear_track();
      sram_delay = 0;
      ps_mode    = 0;
      push_words(8'h10, 1);
      do_start(8'h10, 9'd1);
      wait_done(200, ok, dc);
      checks += 5;
      if (!ok) begin errors++; $display("FAIL single_done: read_done=0 required 1 within 200 cycles"); end
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b required 0", busy); end
      if (dc != last_cons_cyc + 1) begin errors++; $display("FAIL single_done_time: got cycle %0d required %0d", dc, last_cons_cyc + 1); end
      if (first_valid_cyc - start_cyc != 3) begin errors++; $display("FAIL single_latency: got %0d required 3", first_valid_cyc - start_cyc); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL single_left: got %0d words outstanding required 0", exp_q.size()); end
   endtask

   task automatic test_streaming();
      bit ok;
      int dc;
      clear_track();
      sram_delay = 0;
      ps_mode    = 0;
      push_words(8'h20, 4);
      do_start(8'h20, 9'd4);
      wait_done(1000, ok, dc);
      checks += 5;
      if (!ok) begin errors++; $display("FAIL stream_done: read_done=0 required 1 within 1000 cycles"); end
      if (valid_cnt != 128) begin errors++; $display("FAIL stream_valid_cnt: got %0d required 128", valid_cnt); end
      if (last_valid_cyc - first_valid_cyc + 1 != 128) begin errors++; $display("FAIL stream_gaps: span %0d required 128", last_valid_cyc - first_valid_cyc + 1); end
      if (cs_pulses != 4) begin errors++; $display("FAIL stream_cs_pulses: got %0d required 4", cs_pulses); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_backpressure_wrap();
      bit ok;
      int dc;
      logic [AW-1:0] exp_a;
      clear_track();
      sram_delay = 0;
      ps_mode    = 1;
      push_words(8'hFE, 3);
      do_start(8'hFE, 9'd3);
      wait_done(2000, ok, dc);
      checks += 4;
      if (!ok) begin errors++; $display("FAIL bp_done: read_done=0 required 1 within 2000 cycles"); end
      if (!hold_seen) begin errors++; $display("FAIL bp_hold: HOLD seen=0 required 1"); end
      if (cs_pulses != 3) begin errors++; $display("FAIL bp_cs_pulses: got %0d required 3", cs_pulses); end
      if (addr_q.size() != 3) begin errors++; $display("FAIL bp_addr_cnt: got %0d required 3", addr_q.size()); end
      exp_a = 8'hFE;
      while (addr_q.size() > 0) begin
         logic [AW-1:0] got_a;
         got_a = addr_q.pop_front();
         checks++;
         if (got_a !== exp_a) begin errors++; $display("FAIL bp_addr: got %h required %h", got_a, exp_a); end
         exp_a = exp_a + 8'd1;
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d required 0", exp_q.size()); end
      ps_mode = 0;
   endtask

   task automatic test_zero_words();
      clear_track();
      do_start(8'h70, 9'd0);
      @(negedge clk);
      checks += 3;
      if (read_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", read_done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
      @(negedge clk);
      if (read_done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b required 0", read_done); end
      repeat (6) @(negedge clk);
      checks++;
      if (cs_pulses != 0) begin errors++; $display("FAIL zero_cs: got %0d required 0", cs_pulses); end
   endtask

   task automatic test_start_while_busy();
      bit ok;
      int dc;
      clear_track();
      sram_delay = 0;
      ps_mode    = 2;
      push_words(8'h30, 2);
      do_start(8'h30, 9'd2);
      repeat (10) @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = 8'h80;
      num_words = 9'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(2000, ok, dc);
      repeat (10) @(negedge clk);
      checks += 4;
      if (!ok) begin errors++; $display("FAIL busy_done: read_done=0 required 1 within 2000 cycles"); end
      if (cs_pulses != 2) begin errors++; $display("FAIL busy_cs_pulses: got %0d required 2", cs_pulses); end
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b required 0", busy); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL busy_left: got %0d required 0", exp_q.size()); end
      if (addr_q.size() > 0) begin
         checks++;
         if (addr_q[0] !== 8'h30) begin errors++; $display("FAIL busy_addr: got %h required 30", addr_q[0]); end
      end
      ps_mode = 0;
   endtask

   task automatic test_slow_sram();
      bit ok;
      int dc;
      clear_track();
      sram_delay = 5;
      ps_mode    = 0;
      push_words(8'h40, 2);
      do_start(8'h40, 9'd2);
      wait_done(1000, ok, dc);
      checks += 4;
      if (!ok) begin errors++; $display("FAIL slow_done: read_done=0 required 1 within 1000 cycles"); end
      if (first_valid_cyc - start_cyc != 8) begin errors++; $display("FAIL slow_latency: got %0d required 8", first_valid_cyc - start_cyc); end
      if (cs_pulses != 2) begin errors++; $display("FAIL slow_cs_pulses: got %0d required 2", cs_pulses); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL slow_left: got %0d required 0", exp_q.size()); end
      sram_delay = 0;
   endtask

   task automatic test_mid_reset();
      bit ok;
      bit seen;
      int dc;
      // Reset while waiting on a slow SRAM
      clear_track();
      sram_delay = 5;
      push_words(8'h50, 2);
      do_start(8'h50, 9'd2);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dbg_state == ST_WAIT) begin seen = 1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL mr_wait_reached: state=%0d required WAIT", dbg_state); end
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      flush_after_reset();
      checks += 5;
      if (cs_n !== 1'b1 || address !== '0) begin errors++; $display("FAIL mr1_sram: cs_n=%b address=%h required 1/00", cs_n, address); end
      if (P_valid !== 1'b0 || P_out !== 1'b0) begin errors++; $display("FAIL mr1_out: P_valid=%b P_out=%b required 0/0", P_valid, P_out); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mr1_busy: got %b required 0", busy); end
      if (read_done !== 1'b0) begin errors++; $display("FAIL mr1_done: got %b required 0", read_done); end
      if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL mr1_state: got %0d required 0", dbg_state); end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;

      // Reset in the middle of shifting a word
      sram_delay = 0;
      push_words(8'h58, 2);
      do_start(8'h58, 9'd2);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (P_valid) begin seen = 1; break; end
      end
      repeat (10) @(negedge clk);
      checks++;
      if (!seen) begin errors++; $display("FAIL mr_shift_reached: P_valid=0 required 1"); end
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      flush_after_reset();
      checks += 3;
      if (P_valid !== 1'b0 || P_out !== 1'b0) begin errors++; $display("FAIL mr2_out: P_valid=%b P_out=%b required 0/0", P_valid, P_out); end
      if (busy !== 1'b0 || cs_n !== 1'b1) begin errors++; $display("FAIL mr2_ctl: busy=%b cs_n=%b required 0/1", busy, cs_n); end
      if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL mr2_state: got %0d required 0", dbg_state); end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (P_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_no_resume: P_valid=%b busy=%b required 0/0", P_valid, busy); end

      // Fresh readout after reset
      clear_track();
      push_words(8'h60, 2);
      do_start(8'h60, 9'd2);
      wait_done(1000, ok, dc);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL mr_after_done: read_done=0 required 1 within 1000 cycles"); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL mr_after_left: got %0d required 0", exp_q.size()); end
      if (addr_q.size() == 0 || addr_q[0] !== 8'h60) begin errors++; $display("FAIL mr_after_addr: first address wrong or missing, required 60"); end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence and report ----------------
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[8'h10] = 32'hA5A5_0F0F;
      test_reset();
      test_single_word();
      test_streaming();
      test_backpressure_wrap();
      test_zero_words();
      test_start_while_busy();
      test_slow_sram();
      test_mid_reset();
      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM word width and serial frame length.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a readout; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first SRAM address; captured when start is accepted.
REQ-007 num_words  input  ADDR_W+1  word count, range 0..2^ADDR_W; captured when start is accepted.
REQ-008 cs_n  output  1  SRAM chip select, active-low.
REQ-009 we_n  output  1  SRAM write enable, active-low; driven constant 1 (read-only block).
REQ-010 address  output  ADDR_W  SRAM read address.
REQ-011 ry  input  1  SRAM ready; read_data is valid in any cycle where ry=1 after a request.
REQ-012 read_data  input  DATA_W  SRAM read data.
REQ-013 P_s  input  1  downstream shift strobe; consumes one bit when P_s=1 and P_valid=1.
REQ-014 P_out  output  1  serial data, MSB first.
REQ-015 P_valid  output  1  P_out holds a valid bit.
REQ-016 busy  output  1  readout in progress.
REQ-017 read_done  output  1  one-cycle pulse when the last bit of the last word is consumed.

Function
REQ-018 Control flow shall be IDLE -> REQ -> WAIT -> (REQ | HOLD | DRAIN) -> IDLE.
- IDLE -> REQ: start=1 and num_words>0.
- start=1 with num_words=0: stay in IDLE, pulse read_done on the next cycle, busy stays 0.
REQ-019 REQ shall last exactly one cycle: cs_n=0, address=base_addr+word_index mod 2^ADDR_W; it then moves to WAIT.
REQ-020 WAIT shall hold cs_n=1 and address stable until ry=1; read_data is captured into the one-word holding buffer on that edge; the wait has no timeout.
REQ-021 After a capture, the FSM shall go to:
- REQ, if words remain and the buffer will be free on the next cycle;
- HOLD, if words remain and the buffer is full; HOLD then moves to REQ on the cycle after the buffer empties;
- DRAIN, if all words have been requested.
REQ-022 The output shifter shall load from the holding buffer, freeing it, whenever the shifter is empty or its final bit is consumed in the same cycle. Back-to-back words shall therefore stream with zero bubble cycles.
REQ-023 P_valid=1 whenever the shifter holds unconsumed bits; P_out=shifter MSB when P_valid=1, otherwise 0.
REQ-024 Each consume (P_s=1 and P_valid=1) shall left-shift the shifter and increment a bit counter 0..DATA_W-1; the word is empty after DATA_W consumes.
REQ-025 P_s=1 while P_valid=0 shall be ignored.
REQ-026 DRAIN -> IDLE after the final consume. read_done shall pulse in the cycle after that consume, and busy shall fall in the same cycle.
REQ-027 busy=1 from the cycle after start is accepted until read_done.
REQ-028 start during busy shall be ignored, with no effect on captured parameters.
REQ-029 Address wrap: base_addr+num_words>2^ADDR_W shall wrap modulo 2^ADDR_W without error.
REQ-030 Read latency (start to first P_valid) = 3 + ry wait cycles.
REQ-031 At most one SRAM request shall be outstanding at any time.

Reset
REQ-032 rst=0 shall immediately force the following, regardless of the in-flight operation:
- FSM=IDLE, holding buffer and shifter empty, counters 0;
- cs_n=1, we_n=1, address=0;
- P_out=0, P_valid=0, busy=0, read_done=0.
REQ-033 Reset release shall require a fresh start; no pending read or partial word survives reset.

Verification
REQ-034 Single word: ry one cycle after REQ, base_addr=0x10, num_words=1, mem[0x10]=0xA5A5_0F0F, P_s held 1 -> 32 P_out bits 1010...1111 MSB first, then read_done one cycle after the last bit.
REQ-035 Streaming: num_words=4, ry immediate, P_s held 1 -> exactly 128 consecutive P_valid cycles with no gaps, and exactly 4 cs_n=0 pulses.
REQ-036 Backpressure and wrap: base_addr=0xFE, num_words=3, P_s toggling 1/0 -> addresses 0xFE, 0xFF, 0x00; the FSM enters HOLD; no cs_n pulse while the buffer is full; data order preserved.
REQ-037 Edge starts:
- num_words=0 -> read_done pulse, no cs_n activity;
- start asserted during busy -> ignored, output unchanged.
REQ-038 Slow SRAM: ry delayed 5 cycles per read -> address stable throughout WAIT, single capture, first P_valid at cycle 8 after start.
REQ-039 Mid-operation reset: rst=0 during WAIT and again mid-shift -> all outputs reach reset values asynchronously; a subsequent start reads correctly from the new base_addr.
